// File: rtl/cv32e40x_register_file_pair_seq.sv
// Register file with native even/odd pair access. Pairs that exceed the physical port
// count are serialised over two cycles by independent read and write sequencers.
module cv32e40x_register_file_pair_seq #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_RPORTS = 2,
    parameter int unsigned NUM_WPORTS = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_valid_i,
    output logic                      rd_ready_o,
    input  logic                      rd_pair_i,
    input  logic [2*ADDR_WIDTH-1:0]   raddr_i,
    output logic                      rd_rvalid_o,
    output logic [4*DATA_WIDTH-1:0]   rdata_o,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic                      wr_pair_i,
    input  logic [ADDR_WIDTH-1:0]     waddr_i,
    input  logic [2*DATA_WIDTH-1:0]   wdata_i
);
    localparam int NumRegs = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ADDR_WIDTH-2:0] base_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef enum logic {WIdle, WHi} wstate_e;
    typedef enum logic {RIdle, RHi} rstate_e;

    if (!(NUM_RPORTS == 2 || NUM_RPORTS == 4) || !(NUM_WPORTS == 1 || NUM_WPORTS == 2))
    begin : gen_param_check
        $error("cv32e40x_register_file_pair_seq: NUM_RPORTS must be 2/4, NUM_WPORTS 1/2");
    end

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;
    data_t   regs_q [NumRegs];
    addr_t   pend_addr_q, pend_addr_d;
    data_t   pend_data_q, pend_data_d;
    base_t   base_a_q, base_a_d, base_b_q, base_b_d;
    data_t   lo_a_q, lo_a_d, lo_b_q, lo_b_d;
    data_t   rdata_q [4];
    data_t   rdata_d [4];
    logic    rvalid_q, rvalid_d;

    logic    wr_acc, rd_acc;
    logic    we_lo, we_hi, we_hi_commit, we_pend;
    addr_t   wa_lo, wa_hi;
    data_t   wd_lo, wd_hi;
    addr_t   ra_a, ra_b;
    addr_t   rport_addr [4];
    data_t   rport_data [4];

    assign wr_ready_o  = (wstate_q == WIdle);
    assign rd_ready_o  = (rstate_q == RIdle);
    assign wr_acc      = wr_valid_i && wr_ready_o;
    assign rd_acc      = rd_valid_i && rd_ready_o;
    assign rd_rvalid_o = rvalid_q;
    assign rdata_o     = {rdata_q[3], rdata_q[2], rdata_q[1], rdata_q[0]};

    // Write slots: even/single word and odd word of an accepted request, plus the
    // pending odd word being drained in WHi.
    assign we_lo        = wr_acc;
    assign wa_lo        = wr_pair_i ? {waddr_i[ADDR_WIDTH-1:1], 1'b0} : waddr_i;
    assign wd_lo        = wdata_i[DATA_WIDTH-1:0];
    assign we_hi        = wr_acc && wr_pair_i;
    assign wa_hi        = {waddr_i[ADDR_WIDTH-1:1], 1'b1};
    assign wd_hi        = wdata_i[2*DATA_WIDTH-1:DATA_WIDTH];
    assign we_hi_commit = we_hi && (NUM_WPORTS == 2);
    assign we_pend      = (wstate_q == WHi);

    // Write-first view: the odd word of a serialised pair is visible from its accept cycle.
    function automatic data_t rf_read(addr_t a);
        if (a == '0) return '0;
        if (we_lo && wa_lo == a) return wd_lo;
        if (we_hi && wa_hi == a) return wd_hi;
        if (we_pend && pend_addr_q == a) return pend_data_q;
        return regs_q[a];
    endfunction

    always_comb begin
        ra_a = raddr_i[ADDR_WIDTH-1:0];
        ra_b = raddr_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
        if (rstate_q == RHi) begin
            rport_addr[0] = {base_a_q, 1'b1};
            rport_addr[1] = {base_b_q, 1'b1};
        end else if (rd_pair_i) begin
            rport_addr[0] = {ra_a[ADDR_WIDTH-1:1], 1'b0};
            rport_addr[1] = {ra_b[ADDR_WIDTH-1:1], 1'b0};
        end else begin
            rport_addr[0] = ra_a;
            rport_addr[1] = ra_b;
        end
        rport_addr[2] = {ra_a[ADDR_WIDTH-1:1], 1'b1};
        rport_addr[3] = {ra_b[ADDR_WIDTH-1:1], 1'b1};
        for (int i = 0; i < 4; i++) begin
            rport_data[i] = (i < int'(NUM_RPORTS)) ? rf_read(rport_addr[i]) : '0;
        end
    end

    always_comb begin
        wstate_d    = wstate_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        unique case (wstate_q)
            WIdle: begin
                if (we_hi && NUM_WPORTS == 1) begin
                    wstate_d    = WHi;
                    pend_addr_d = wa_hi;
                    pend_data_d = wd_hi;
                end
            end
            WHi:     wstate_d = WIdle;
            default: wstate_d = WIdle;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        lo_a_d   = lo_a_q;
        lo_b_d   = lo_b_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        unique case (rstate_q)
            RIdle: begin
                if (rd_acc) begin
                    if (rd_pair_i && NUM_RPORTS == 2) begin
                        // Even words are parked so rdata_o keeps its value until the pulse.
                        lo_a_d   = rport_data[0];
                        lo_b_d   = rport_data[1];
                        base_a_d = ra_a[ADDR_WIDTH-1:1];
                        base_b_d = ra_b[ADDR_WIDTH-1:1];
                        rstate_d = RHi;
                    end else begin
                        rvalid_d   = 1'b1;
                        rdata_d[0] = rport_data[0];
                        rdata_d[1] = rport_data[1];
                        rdata_d[2] = rd_pair_i ? rport_data[2] : '0;
                        rdata_d[3] = rd_pair_i ? rport_data[3] : '0;
                    end
                end
            end
            RHi: begin
                rvalid_d   = 1'b1;
                rdata_d[0] = lo_a_q;
                rdata_d[1] = lo_b_q;
                rdata_d[2] = rport_data[0];
                rdata_d[3] = rport_data[1];
                rstate_d   = RIdle;
            end
            default: rstate_d = RIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 1; i < NumRegs; i++) begin
                if (we_lo && wa_lo == addr_t'(i)) begin
                    regs_q[i] <= wd_lo;
                end else if (we_hi_commit && wa_hi == addr_t'(i)) begin
                    regs_q[i] <= wd_hi;
                end else if (we_pend && pend_addr_q == addr_t'(i)) begin
                    regs_q[i] <= pend_data_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q    <= WIdle;
            rstate_q    <= RIdle;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            lo_a_q      <= '0;
            lo_b_q      <= '0;
            rvalid_q    <= 1'b0;
            for (int i = 0; i < 4; i++) rdata_q[i] <= '0;
        end else begin
            wstate_q    <= wstate_d;
            rstate_q    <= rstate_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            lo_a_q      <= lo_a_d;
            lo_b_q      <= lo_b_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_cv32e40x_register_file_pair_seq.sv
// Bench for the pair register file: a 2R/1W and a 4R/2W instance share stimulus and are
// checked every cycle against an architectural model, plus directed literal checks.
module tb_cv32e40x_register_file_pair_seq;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rd_valid = 1'b0, rd_pair = 1'b0, wr_valid = 1'b0, wr_pair = 1'b0;
    logic [9:0]        raddr = '0;
    logic [4:0]        waddr = '0;
    logic [63:0]       wdata = '0;
    logic [1:0]        rd_ready_s, wr_ready_s, rvalid_s;
    logic [1:0][127:0] rdata_s;
    int                n_vec = 0;
    int                n_err = 0;

    always #5 clk = ~clk;

    cv32e40x_register_file_pair_seq #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RPORTS(2), .NUM_WPORTS(1)
    ) u_dut_2r1w (
        .clk(clk), .rst_n(rst_n),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_ready_s[0]), .rd_pair_i(rd_pair),
        .raddr_i(raddr), .rd_rvalid_o(rvalid_s[0]), .rdata_o(rdata_s[0]),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_s[0]), .wr_pair_i(wr_pair),
        .waddr_i(waddr), .wdata_i(wdata)
    );

    cv32e40x_register_file_pair_seq #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RPORTS(4), .NUM_WPORTS(2)
    ) u_dut_4r2w (
        .clk(clk), .rst_n(rst_n),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_ready_s[1]), .rd_pair_i(rd_pair),
        .raddr_i(raddr), .rd_rvalid_o(rvalid_s[1]), .rdata_o(rdata_s[1]),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_s[1]), .wr_pair_i(wr_pair),
        .waddr_i(waddr), .wdata_i(wdata)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] word(int c, int k);
        return rdata_s[c][k*32 +: 32];
    endfunction

    // Architectural model; config 0 = 2R/1W, config 1 = 4R/2W.
    logic [31:0] mem [2][32];
    bit          wbusy [2];
    bit          rbusy [2];
    bit          m_rvalid [2];
    logic [4:0]  hold_a [2];
    logic [4:0]  hold_b [2];
    logic [31:0] hold0 [2];
    logic [31:0] hold1 [2];
    logic [31:0] m_rdata [2][4];

    function automatic void m_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 32; r++) mem[c][r] = '0;
            for (int k = 0; k < 4; k++) m_rdata[c][k] = '0;
            wbusy[c] = 0; rbusy[c] = 0; m_rvalid[c] = 0;
        end
    endfunction

    function automatic void m_step(int c);
        logic [4:0] a, b, base;
        bit nv;
        nv = 0;
        // Writes become visible in full at acceptance; reads below see them.
        if (wbusy[c]) begin
            wbusy[c] = 0;
        end else if (wr_valid) begin
            if (wr_pair) begin
                base = {waddr[4:1], 1'b0};
                if (base != 0) mem[c][base] = wdata[31:0];
                mem[c][{waddr[4:1], 1'b1}] = wdata[63:32];
                wbusy[c] = (c == 0);
            end else if (waddr != 0) begin
                mem[c][waddr] = wdata[31:0];
            end
        end
        a = raddr[4:0];
        b = raddr[9:5];
        if (rbusy[c]) begin
            m_rdata[c][0] = hold0[c];
            m_rdata[c][1] = hold1[c];
            m_rdata[c][2] = mem[c][{hold_a[c][4:1], 1'b1}];
            m_rdata[c][3] = mem[c][{hold_b[c][4:1], 1'b1}];
            nv = 1;
            rbusy[c] = 0;
        end else if (rd_valid) begin
            if (rd_pair) begin
                a[0] = 1'b0;
                b[0] = 1'b0;
            end
            if (rd_pair && c == 0) begin
                hold0[c] = mem[c][a];
                hold1[c] = mem[c][b];
                hold_a[c] = a;
                hold_b[c] = b;
                rbusy[c] = 1;
            end else begin
                m_rdata[c][0] = mem[c][a];
                m_rdata[c][1] = mem[c][b];
                m_rdata[c][2] = rd_pair ? mem[c][{a[4:1], 1'b1}] : 32'h0;
                m_rdata[c][3] = rd_pair ? mem[c][{b[4:1], 1'b1}] : 32'h0;
                nv = 1;
            end
        end
        m_rvalid[c] = nv;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) m_reset();
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("rd_ready c%0d", c), 32'(rd_ready_s[c]), 32'(!rbusy[c]));
            chk($sformatf("wr_ready c%0d", c), 32'(wr_ready_s[c]), 32'(!wbusy[c]));
            chk($sformatf("rvalid c%0d", c), 32'(rvalid_s[c]), 32'(m_rvalid[c]));
            for (int k = 0; k < 4; k++)
                chk($sformatf("rdata[%0d] c%0d", k, c), word(c, k), m_rdata[c][k]);
        end
        if (rst_n) begin
            m_step(0);
            m_step(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_read(int c, string tag, logic [31:0] e0, logic [31:0] e1,
                               logic [31:0] e2, logic [31:0] e3);
        chk($sformatf("%s rvalid c%0d", tag, c), 32'(rvalid_s[c]), 32'd1);
        chk($sformatf("%s w0 c%0d", tag, c), word(c, 0), e0);
        chk($sformatf("%s w1 c%0d", tag, c), word(c, 1), e1);
        chk($sformatf("%s w2 c%0d", tag, c), word(c, 2), e2);
        chk($sformatf("%s w3 c%0d", tag, c), word(c, 3), e3);
    endtask

    task automatic read_all_zero();
        for (int i = 1; i < 32; i++) begin
            rd_valid = 1'b1; rd_pair = 1'b0; raddr = {5'd0, 5'(i)};
            tick();
            for (int c = 0; c < 2; c++) expect_read(c, "rst_read", 0, 0, 0, 0);
        end
        rd_valid = 1'b0;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        read_all_zero();

        // Pair write to base 0 only lands in x1.
        wr_valid = 1'b1; wr_pair = 1'b1; waddr = 5'd0; wdata = {32'h6, 32'h5};
        tick();
        wr_valid = 1'b0;
        tick();
        rd_valid = 1'b1; rd_pair = 1'b0; raddr = {5'd1, 5'd0};
        tick();
        rd_valid = 1'b0;
        for (int c = 0; c < 2; c++) expect_read(c, "x0", 0, 32'h6, 0, 0);

        // Same-cycle write and read of x5.
        wr_valid = 1'b1; wr_pair = 1'b0; waddr = 5'd5; wdata = {32'h0, 32'hDEADBEEF};
        rd_valid = 1'b1; rd_pair = 1'b0; raddr = {5'd5, 5'd5};
        tick();
        wr_valid = 1'b0; rd_valid = 1'b0;
        for (int c = 0; c < 2; c++) expect_read(c, "bypass", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);

        // Pair write base 7 (-> 6), pair read issued in the 2R/1W WHi cycle.
        wr_valid = 1'b1; wr_pair = 1'b1; waddr = 5'd7; wdata = {32'h22222222, 32'h11111111};
        tick();
        wr_valid = 1'b0;
        chk("pair7 wr_ready c0 stall", 32'(wr_ready_s[0]), 32'd0);
        chk("pair7 wr_ready c1", 32'(wr_ready_s[1]), 32'd1);
        rd_valid = 1'b1; rd_pair = 1'b1; raddr = {5'd0, 5'd6};
        tick();
        rd_valid = 1'b0;
        chk("pair7 wr_ready c0 back", 32'(wr_ready_s[0]), 32'd1);
        chk("pair7 rvalid c0 early", 32'(rvalid_s[0]), 32'd0);
        chk("pair7 rd_ready c0 busy", 32'(rd_ready_s[0]), 32'd0);
        expect_read(1, "pair7", 32'h11111111, 32'h0, 32'h22222222, 32'h6);
        tick();
        expect_read(0, "pair7", 32'h11111111, 32'h0, 32'h22222222, 32'h6);

        // Pair write base 10, pair read next cycle.
        wr_valid = 1'b1; wr_pair = 1'b1; waddr = 5'd10; wdata = {32'hB, 32'hA};
        tick();
        wr_valid = 1'b0;
        chk("pair10 wr_ready c1", 32'(wr_ready_s[1]), 32'd1);
        rd_valid = 1'b1; rd_pair = 1'b1; raddr = {5'd10, 5'd10};
        tick();
        rd_valid = 1'b0;
        expect_read(1, "pair10", 32'hA, 32'hA, 32'hB, 32'hB);
        chk("pair10 rd_ready c1", 32'(rd_ready_s[1]), 32'd1);
        chk("pair10 wr_ready c1 after", 32'(wr_ready_s[1]), 32'd1);
        tick();
        expect_read(0, "pair10", 32'hA, 32'hA, 32'hB, 32'hB);

        // Reset while 2R/1W sits in WHi and RHi.
        tick();
        wr_valid = 1'b1; wr_pair = 1'b1; waddr = 5'd12; wdata = {32'h13131313, 32'h12121212};
        rd_valid = 1'b1; rd_pair = 1'b1; raddr = {5'd12, 5'd12};
        tick();
        wr_valid = 1'b0; rd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst rvalid c0", 32'(rvalid_s[0]), 32'd0);
        chk("midrst rd_ready c0", 32'(rd_ready_s[0]), 32'd1);
        chk("midrst wr_ready c0", 32'(wr_ready_s[0]), 32'd1);
        tick();
        chk("midrst rvalid c0 later", 32'(rvalid_s[0]), 32'd0);
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("postrst rd_ready c%0d", c), 32'(rd_ready_s[c]), 32'd1);
            chk($sformatf("postrst wr_ready c%0d", c), 32'(wr_ready_s[c]), 32'd1);
            chk($sformatf("postrst rvalid c%0d", c), 32'(rvalid_s[c]), 32'd0);
        end
        rd_valid = 1'b1; rd_pair = 1'b0; raddr = {5'd12, 5'd13};
        tick();
        rd_valid = 1'b0;
        for (int c = 0; c < 2; c++) expect_read(c, "x13", 0, 0, 0, 0);

        // Random traffic, checked by the model every cycle.
        for (int n = 0; n < 1500; n++) begin
            rd_valid = 1'($urandom);
            rd_pair  = 1'($urandom);
            raddr    = 10'($urandom);
            wr_valid = 1'($urandom);
            wr_pair  = 1'($urandom);
            waddr    = 5'($urandom);
            wdata    = {$urandom, $urandom};
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        rd_valid = 1'b0; wr_valid = 1'b0;
        tick();

        // Mid-run reset, then everything reads back as zero.
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        read_all_zero();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cv32e40x_register_file_pair_seq.md
# cv32e40x_register_file_pair_seq

Register file with native register-pair (even/odd) access, parametrised in address width, data width and physical read/write port count. Single or paired read/write requests use valid/ready handshakes. When the physical ports cannot serve a pair in one cycle, the block serialises the pair over two cycles with internal sequencers. It sits between the decode/writeback stages and replaces the fixed 4-read/2-write pair wrapper, so cores with 2R/1W storage can support 64-bit pair operands.

## Interface
- ADDR_WIDTH, 5: register address width; 5 = RV32I (32 regs), 4 = RV32E (16 regs).
- DATA_WIDTH, 32: register width.
- NUM_RPORTS, 2: physical read ports; legal values 2 or 4.
- NUM_WPORTS, 1: physical write ports; legal values 1 or 2.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous and active-low.
- rd_valid_i  in  1  read request valid.
- rd_ready_o  out  1  read request accepted when rd_valid_i && rd_ready_o.
- rd_pair_i  in  1  1 = pair read of both operands.
- raddr_i  in  2 x ADDR_WIDTH  operand addresses A and B; LSB ignored when rd_pair_i = 1.
- rd_rvalid_o  out  1  one-cycle pulse; rdata_o is valid.
- rdata_o  out  4 x DATA_WIDTH  [0] = A even/single, [1] = B even/single, [2] = A odd, [3] = B odd; [2]/[3] are 0 for single reads.
- wr_valid_i  in  1  write request valid.
- wr_ready_o  out  1  write request accepted when wr_valid_i && wr_ready_o.
- wr_pair_i  in  1  1 = pair write.
- waddr_i  in  ADDR_WIDTH  write address; LSB ignored when wr_pair_i = 1.
- wdata_i  in  2 x DATA_WIDTH  [0] = even/single data, [1] = odd data.

## Operation
- Storage is 2^ADDR_WIDTH x DATA_WIDTH flops.
- x0 always reads 0 and writes to x0 are dropped. A pair write to base 0 updates x1 only.
- Write sequencer, states W_IDLE and W_HI:
  - W_IDLE: wr_ready_o = 1. A single write commits on the accept edge.
  - Pair write with NUM_WPORTS = 2: even and odd commit on the accept edge.
  - Pair write with NUM_WPORTS = 1: even commits on the accept edge. The odd address and data are captured in a pending buffer, and the sequencer goes to W_HI.
  - W_HI: wr_ready_o = 0. The pending odd word commits at the end of this cycle, then the sequencer returns to W_IDLE.
- Read sequencer, states R_IDLE and R_HI:
  - R_IDLE: rd_ready_o = 1. Data is registered into rdata_o; rd_rvalid_o pulses the cycle after accept.
  - Single read, or pair read with NUM_RPORTS = 4: complete in the accept cycle.
  - Pair read with NUM_RPORTS = 2: the even words are captured in the accept cycle, and the sequencer goes to R_HI.
  - R_HI: rd_ready_o = 0. The odd words (base | 1) are read, and rd_rvalid_o pulses the following cycle with all four words.
- Visibility: a write is architecturally visible from its accept cycle. Every array read uses this priority:
  1. the write committing this cycle (write-first bypass),
  2. the pending W_HI odd word,
  3. the array.
- Read and write sequencers are independent. Simultaneous accepts are legal in any state combination.
- rdata_o holds its last value when rd_rvalid_o = 0.

## Timing
- Reset (asynchronous assert, synchronous release): all registers = 0, rdata_o = 0, rd_rvalid_o = 0, rd_ready_o = 1, wr_ready_o = 1, both sequencers IDLE, pending buffer cleared.
- Reset during W_HI: the pending odd write is discarded; the even word is also cleared by the reset.
- Reset during R_HI: no rd_rvalid_o is produced.
- Read latency:
  - 1 cycle: single read, or pair read with NUM_RPORTS = 4.
  - 2 cycles: pair read with NUM_RPORTS = 2.
- Write throughput:
  - 1 request per cycle, except a pair write with NUM_WPORTS = 1, which takes 2 cycles.
- Back-to-back: a new request is accepted in the cycle the sequencer returns to IDLE, i.e. the cycle after W_HI or R_HI.
- ready depends only on state, never on valid (no combinational valid-to-ready path).
- Illegal parameter values (NUM_RPORTS not 2/4, NUM_WPORTS not 1/2) fail at elaboration.

## Test plan
- Reset check: assert rst_n = 0 mid-run, release, then read x1..x31 one at a time -> all 0, rd_rvalid_o exactly one cycle after each accept.
- Single write then read, same cycle (NUM_WPORTS = 1): write x5 = 0xDEADBEEF and read x5 in the same cycle -> rdata_o[0] = 0xDEADBEEF next cycle (bypass).
- Pair write then pair read, 2R/1W:
  - Write: pair write base 7 (treated as 6) with {0x11111111, 0x22222222}; wr_ready_o = 0 for exactly one cycle.
  - Read in the W_HI cycle: pair read A = 6, B = 0 -> rdata_o = {0x11111111, 0, 0x22222222, x1 value}, rd_rvalid_o 2 cycles after accept.
- 4R/2W pair: pair write base 10 {0xA, 0xB}, next cycle pair read A = 10, B = 10 -> all of rdata_o[0..3] = {0xA, 0xA, 0xB, 0xB} one cycle later; ready never drops.
- x0 handling: pair write base 0 {0x5, 0x6} -> a later read of x0 returns 0, x1 returns 0x6.
- Reset mid-sequence: assert rst_n in the W_HI and R_HI cycles -> x13 stays 0 (pair write base 12), no rd_rvalid_o pulse, both readys = 1 after release.
